// File: rtl/udp_ip_framer.sv
// udp_ip_framer: grants the legacy UDP sender, wraps its payload in Ethernet/IPv4/UDP headers and
// streams the frame byte-wise to the MAC with minimum-size padding, inter-frame gap and oversize drop.
module udp_ip_framer #(
  parameter logic [15:0] SRC_PORT   = 16'd1024,
  parameter logic [7:0]  IP_TTL     = 8'h80,
  parameter logic [10:0] MAX_LEN    = 11'd1472,
  parameter logic [4:0]  IFG        = 5'd12,
  parameter logic [15:0] IDENT_INIT = 16'h0000
) (
  input  logic        tx_clock,
  input  logic        reset_n,
  input  logic        udp_tx_request,
  input  logic [10:0] udp_tx_length,
  input  logic [7:0]  udp_tx_data,
  output logic        udp_tx_enable,
  output logic        udp_tx_active,
  input  logic [47:0] This_MAC,
  input  logic [31:0] This_IP,
  input  logic [47:0] To_MAC,
  input  logic [31:0] To_IP,
  input  logic [15:0] To_Port,
  output logic [7:0]  mac_tx_data,
  output logic        mac_tx_valid,
  output logic        mac_tx_last,
  input  logic        mac_tx_ready,
  output logic [7:0]  drop_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_CSUM, S_GRANT, S_HEADER, S_PAYLOAD, S_PAD, S_DRAIN, S_GAP
  } state_t;

  function automatic logic [19:0] ext20(input logic [15:0] w);
    return {4'd0, w};
  endfunction

  function automatic logic [19:0] fold20(input logic [19:0] a);
    return {4'd0, a[15:0]} + {16'd0, a[19:16]};
  endfunction

  state_t      r_state;
  logic [10:0] r_len;
  logic [47:0] r_dst_mac;
  logic [47:0] r_src_mac;
  logic [31:0] r_src_ip;
  logic [31:0] r_dst_ip;
  logic [15:0] r_dst_port;
  logic [15:0] r_ident;
  logic [19:0] r_acc;
  logic [15:0] r_csum;
  logic [1:0]  r_csum_cnt;
  logic [10:0] r_cnt;
  logic [4:0]  r_gap;
  logic        r_req_low;
  logic        r_enable;
  logic [7:0]  r_drop;
  logic [7:0]  r_out_data;
  logic        r_out_valid;
  logic        r_out_last;

  logic [15:0]  w_ip_len;
  logic [15:0]  w_udp_len;
  logic [19:0]  w_sum9;
  logic [19:0]  w_fold;
  logic [335:0] w_hdr;
  logic [335:0] w_hdr_sh;
  logic [7:0]   w_hdr_byte;
  logic         w_load;
  logic [10:0]  w_frame_end;
  logic         w_pay_last;
  logic         w_long;

  assign w_ip_len  = {5'd0, r_len} + 16'd28;
  assign w_udp_len = {5'd0, r_len} + 16'd8;
  assign w_sum9 = ext20(16'h4500) + ext20(w_ip_len) + ext20(r_ident) + ext20({IP_TTL, 8'h11})
                + ext20(r_src_ip[31:16]) + ext20(r_src_ip[15:0])
                + ext20(r_dst_ip[31:16]) + ext20(r_dst_ip[15:0]);
  assign w_fold = fold20(r_acc);

  // Whole 42-byte header as one big-endian vector; byte n is selected by shifting it to the top.
  assign w_hdr = {r_dst_mac, r_src_mac, 16'h0800, 8'h45, 8'h00, w_ip_len, r_ident, 16'h0000,
                  IP_TTL, 8'h11, r_csum, r_src_ip, r_dst_ip, SRC_PORT, r_dst_port, w_udp_len,
                  16'h0000};
  assign w_hdr_sh   = w_hdr << {r_cnt[5:0], 3'b000};
  assign w_hdr_byte = w_hdr_sh[335:328];

  assign w_load      = !r_out_valid || mac_tx_ready;
  assign w_frame_end = r_len + 11'd42;
  assign w_pay_last  = (r_cnt == (w_frame_end - 11'd1));
  assign w_long      = (w_frame_end >= 11'd60);

  assign udp_tx_active = ((r_state == S_PAYLOAD) && w_load) || (r_state == S_DRAIN);
  assign udp_tx_enable = r_enable;
  assign mac_tx_data   = r_out_data;
  assign mac_tx_valid  = r_out_valid;
  assign mac_tx_last   = r_out_last;
  assign drop_count    = r_drop;

  // Frame sequencer, checksum pipeline and MAC output register.
  always_ff @(posedge tx_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_len       <= 11'd0;
      r_dst_mac   <= 48'd0;
      r_src_mac   <= 48'd0;
      r_src_ip    <= 32'd0;
      r_dst_ip    <= 32'd0;
      r_dst_port  <= 16'd0;
      r_ident     <= IDENT_INIT;
      r_acc       <= 20'd0;
      r_csum      <= 16'd0;
      r_csum_cnt  <= 2'd0;
      r_cnt       <= 11'd0;
      r_gap       <= 5'd0;
      r_req_low   <= 1'b0;
      r_enable    <= 1'b0;
      r_drop      <= 8'd0;
      r_out_data  <= 8'd0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_enable <= 1'b0;
          if (udp_tx_request) begin
            r_len      <= udp_tx_length;
            r_dst_mac  <= To_MAC;
            r_src_mac  <= This_MAC;
            r_src_ip   <= This_IP;
            r_dst_ip   <= To_IP;
            r_dst_port <= To_Port;
            r_csum_cnt <= 2'd0;
            r_state    <= S_CSUM;
          end
        end
        S_CSUM: begin
          r_csum_cnt <= r_csum_cnt + 2'd1;
          case (r_csum_cnt)
            2'd0:    r_acc <= w_sum9;
            2'd1:    r_acc <= w_fold;
            default: begin
              r_csum   <= ~w_fold[15:0];
              r_enable <= 1'b1;
              r_state  <= S_GRANT;
            end
          endcase
        end
        S_GRANT: begin
          r_enable  <= 1'b0;
          r_cnt     <= 11'd0;
          r_gap     <= 5'd0;
          r_req_low <= 1'b0;
          if (r_len > MAX_LEN) begin
            if (r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
            r_state <= S_DRAIN;
          end else begin
            r_state <= S_HEADER;
          end
        end
        S_HEADER: begin
          if (w_load) begin
            r_out_data  <= w_hdr_byte;
            r_out_valid <= 1'b1;
            r_out_last  <= 1'b0;
            r_cnt       <= r_cnt + 11'd1;
            if (r_cnt == 11'd41) r_state <= (r_len == 11'd0) ? S_PAD : S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (w_load) begin
            r_out_data  <= udp_tx_data;
            r_out_valid <= 1'b1;
            r_out_last  <= w_pay_last && w_long;
            r_cnt       <= r_cnt + 11'd1;
            if (w_pay_last) begin
              if (w_long) begin
                r_ident <= r_ident + 16'd1;
                r_state <= S_GAP;
              end else begin
                r_state <= S_PAD;
              end
            end
          end
        end
        S_PAD: begin
          if (!udp_tx_request) r_req_low <= 1'b1;
          if (w_load) begin
            r_out_data  <= 8'h00;
            r_out_valid <= 1'b1;
            r_out_last  <= (r_cnt == 11'd59);
            r_cnt       <= r_cnt + 11'd1;
            if (r_cnt == 11'd59) begin
              r_ident <= r_ident + 16'd1;
              r_state <= S_GAP;
            end
          end
        end
        S_DRAIN: begin
          r_cnt <= r_cnt + 11'd1;
          if (r_cnt == (r_len - 11'd1)) r_state <= S_GAP;
        end
        S_GAP: begin
          if (!udp_tx_request) r_req_low <= 1'b1;
          if (w_load) begin
            r_out_data  <= 8'h00;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
          end
          // The gap is counted only once the final byte has left the output register.
          if (!r_out_valid) begin
            if (r_gap < IFG) begin
              r_gap <= r_gap + 5'd1;
            end else if (r_req_low || !udp_tx_request) begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_ip_framer.sv
// Directed bench for udp_ip_framer: a payload sender model plus a byte scoreboard fed by an
// independent frame builder; a second instance preloaded with ident FFFF covers the ident wrap.
module tb_udp_ip_framer;

  logic        tx_clock = 1'b0;
  logic        reset_n;
  logic        udp_tx_request;
  logic [10:0] udp_tx_length;
  logic [7:0]  udp_tx_data;
  logic        udp_tx_enable, udp_tx_active;
  logic [47:0] this_mac, to_mac;
  logic [31:0] this_ip, to_ip;
  logic [15:0] to_port;
  logic [7:0]  mac_tx_data;
  logic        mac_tx_valid, mac_tx_last, mac_tx_ready;
  logic [7:0]  drop_count;
  logic        w_enable, w_active, w_valid, w_last;
  logic [7:0]  w_data, w_drop;

  int          n_cmp, n_err;
  logic [8:0]  exp_q[$];
  logic [15:0] w_ids[$];
  logic [7:0]  rx_buf[0:1599];
  int          rx_n, act_cnt, pay_idx, w_n;
  logic [7:0]  seed, w_id_hi;
  bit          frame_done, any_valid, rdy_rand;
  logic [15:0] ident_m;

  always #5 tx_clock = ~tx_clock;

  udp_ip_framer dut (
    .tx_clock(tx_clock), .reset_n(reset_n), .udp_tx_request(udp_tx_request),
    .udp_tx_length(udp_tx_length), .udp_tx_data(udp_tx_data), .udp_tx_enable(udp_tx_enable),
    .udp_tx_active(udp_tx_active), .This_MAC(this_mac), .This_IP(this_ip), .To_MAC(to_mac),
    .To_IP(to_ip), .To_Port(to_port), .mac_tx_data(mac_tx_data), .mac_tx_valid(mac_tx_valid),
    .mac_tx_last(mac_tx_last), .mac_tx_ready(mac_tx_ready), .drop_count(drop_count)
  );

  udp_ip_framer #(.IDENT_INIT(16'hFFFF)) dut_w (
    .tx_clock(tx_clock), .reset_n(reset_n), .udp_tx_request(udp_tx_request),
    .udp_tx_length(udp_tx_length), .udp_tx_data(udp_tx_data), .udp_tx_enable(w_enable),
    .udp_tx_active(w_active), .This_MAC(this_mac), .This_IP(this_ip), .To_MAC(to_mac),
    .To_IP(to_ip), .To_Port(to_port), .mac_tx_data(w_data), .mac_tx_valid(w_valid),
    .mac_tx_last(w_last), .mac_tx_ready(mac_tx_ready), .drop_count(w_drop)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pay_byte(input logic [7:0] s, input int i);
    int t;
    t = i * 13 + int'(s);
    return t[7:0];
  endfunction

  function automatic logic [15:0] exp_csum(input int len, input logic [15:0] id);
    logic [31:0] s;
    s = 32'h4500 + 32'(len + 28) + {16'd0, id} + 32'h8011 + {16'd0, this_ip[31:16]}
      + {16'd0, this_ip[15:0]} + {16'd0, to_ip[31:16]} + {16'd0, to_ip[15:0]};
    while (s[31:16] != 16'd0) s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
    return ~s[15:0];
  endfunction

  task automatic push_n(input logic [47:0] v, input int nbytes);
    for (int i = nbytes - 1; i >= 0; i--) exp_q.push_back({1'b0, v[8*i +: 8]});
  endtask

  task automatic push_frame(input int len, input logic [15:0] id, input logic [7:0] sd);
    push_n(to_mac, 6);  push_n(this_mac, 6); push_n(48'h0800, 2); push_n(48'h4500, 2);
    push_n(48'(len + 28), 2); push_n({32'd0, id}, 2); push_n(48'h0, 2); push_n(48'h8011, 2);
    push_n({32'd0, exp_csum(len, id)}, 2); push_n({16'd0, this_ip}, 4); push_n({16'd0, to_ip}, 4);
    push_n(48'd1024, 2); push_n({32'd0, to_port}, 2); push_n(48'(len + 8), 2); push_n(48'h0, 2);
    for (int i = 0; i < len; i++) exp_q.push_back({(i == len - 1) && (len >= 18), pay_byte(sd, i)});
    for (int i = 42 + len; i < 60; i++) exp_q.push_back({i == 59, 8'h00});
  endtask

  // MAC back-pressure: always ready, or a coin flip per cycle.
  always @(posedge tx_clock) begin
    #1;
    mac_tx_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Sender model: the byte shown is consumed at the next edge, then the next one is presented.
  always @(negedge tx_clock) begin
    if (udp_tx_active) begin
      act_cnt++;
      @(posedge tx_clock);
      #1;
      pay_idx++;
      udp_tx_data = pay_byte(seed, pay_idx);
    end
  end

  // Scoreboard: every accepted byte is checked against the next expected {last, data}.
  always @(negedge tx_clock) begin : mon
    logic [8:0] e;
    if (mac_tx_valid) any_valid = 1'b1;
    if (mac_tx_valid && mac_tx_ready) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'bx;
      check("byte", {23'd0, mac_tx_last, mac_tx_data}, {23'd0, e});
      if (rx_n < 1600) rx_buf[rx_n] = mac_tx_data;
      rx_n++;
      if (mac_tx_last) frame_done = 1'b1;
    end
    if (w_valid && mac_tx_ready) begin
      if (w_n == 18) w_id_hi = w_data;
      if (w_n == 19) w_ids.push_back({w_id_hi, w_data});
      w_n = w_last ? 0 : w_n + 1;
    end
  end

  task automatic send_frame(input int len, input logic [7:0] sd, input bit rnd);
    bit drop, ok;
    int flen;
    logic [31:0] s;
    drop = (len > 1472);
    flen = (42 + len < 60) ? 60 : 42 + len;
    if (!drop) push_frame(len, ident_m, sd);
    seed = sd; pay_idx = 0; udp_tx_data = pay_byte(sd, 0); act_cnt = 0; rx_n = 0;
    frame_done = 1'b0; any_valid = 1'b0; rdy_rand = rnd;
    udp_tx_length = 11'(len);
    udp_tx_request = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 6000 && !ok; c++) begin
      @(posedge tx_clock);
      #1;
      ok = drop ? (act_cnt >= len) : frame_done;
    end
    check("done", {31'd0, ok}, 32'd1);
    udp_tx_request = 1'b0;
    rdy_rand = 1'b0;
    repeat (4) @(posedge tx_clock);
    #1;
    check("active_cycles", act_cnt, len);
    if (drop) begin
      check("drain_no_valid", {31'd0, any_valid}, 32'd0);
    end else begin
      check("frame_len", rx_n, flen);
      check("ip_len", {16'd0, rx_buf[16], rx_buf[17]}, 32'(len + 28));
      check("udp_len", {16'd0, rx_buf[38], rx_buf[39]}, 32'(len + 8));
      s = 32'd0;
      for (int i = 14; i < 34; i += 2) s = s + {16'd0, rx_buf[i], rx_buf[i+1]};
      while (s[31:16] != 16'd0) s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
      check("csum_verify", s, 32'h0000FFFF);
      check("sb_left", exp_q.size(), 0);
      ident_m = ident_m + 16'd1;
    end
  endtask

  initial begin
    bit ok;
    int snap;
    n_cmp = 0; n_err = 0; reset_n = 1'b0; udp_tx_request = 1'b0; udp_tx_length = 11'd0;
    udp_tx_data = 8'd0; mac_tx_ready = 1'b1; rdy_rand = 1'b0; seed = 8'd0; ident_m = 16'd0;
    act_cnt = 0; rx_n = 0; w_n = 0; pay_idx = 0; frame_done = 1'b0; any_valid = 1'b0;
    to_mac = 48'h0011_2233_4455; this_mac = 48'h0A0B_0C0D_0E0F;
    this_ip = 32'hC0A8_0001; to_ip = 32'hC0A8_00FE; to_port = 16'd1025;
    repeat (3) @(posedge tx_clock);
    #1;
    check("rst_valid", {31'd0, mac_tx_valid}, 32'd0);
    check("rst_data", {24'd0, mac_tx_data}, 32'd0);
    check("rst_last", {31'd0, mac_tx_last}, 32'd0);
    check("rst_enable", {31'd0, udp_tx_enable}, 32'd0);
    check("rst_active", {31'd0, udp_tx_active}, 32'd0);
    check("rst_drop", {24'd0, drop_count}, 32'd0);
    check("rst_w", {12'd0, w_enable, w_active, w_valid, w_last, w_data, w_drop}, 32'd0);
    reset_n = 1'b1;
    repeat (2) @(posedge tx_clock);
    #1;

    send_frame(1032, 8'h11, 1'b0);
    check("f1032_iplen", {16'd0, rx_buf[16], rx_buf[17]}, 32'h0424);
    check("f1032_udplen", {16'd0, rx_buf[38], rx_buf[39]}, 32'h0410);
    send_frame(60, 8'h22, 1'b0);
    check("f60_iplen", {16'd0, rx_buf[16], rx_buf[17]}, 32'h0058);
    send_frame(10, 8'h33, 1'b0);
    send_frame(1032, 8'h44, 1'b1);
    send_frame(1500, 8'h55, 1'b0);
    check("drop_count", {24'd0, drop_count}, 32'd1);
    send_frame(18, 8'h66, 1'b0);
    check("wrap_frames", w_ids.size(), 5);
    check("wrap_id0", {16'd0, (w_ids.size() > 0) ? w_ids[0] : 16'hxxxx}, 32'hFFFF);
    check("wrap_id1", {16'd0, (w_ids.size() > 1) ? w_ids[1] : 16'hxxxx}, 32'h0000);

    // Reset in the middle of the payload of a 200-byte frame.
    push_frame(200, ident_m, 8'h77);
    seed = 8'h77; pay_idx = 0; udp_tx_data = pay_byte(8'h77, 0); act_cnt = 0; rx_n = 0;
    udp_tx_length = 11'd200;
    udp_tx_request = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 2000 && !ok; c++) begin
      @(posedge tx_clock);
      #1;
      ok = (act_cnt >= 50);
    end
    check("midframe_reached", {31'd0, ok}, 32'd1);
    @(posedge tx_clock);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort_valid", {31'd0, mac_tx_valid}, 32'd0);
    check("abort_last", {31'd0, mac_tx_last}, 32'd0);
    check("abort_data", {24'd0, mac_tx_data}, 32'd0);
    check("abort_active", {31'd0, udp_tx_active}, 32'd0);
    check("abort_drop", {24'd0, drop_count}, 32'd0);
    exp_q.delete();
    udp_tx_request = 1'b0;
    repeat (4) @(posedge tx_clock);
    #1;
    reset_n = 1'b1;
    any_valid = 1'b0;
    snap = act_cnt;
    w_n = 0;
    repeat (300) @(posedge tx_clock);
    #1;
    check("no_resume_valid", {31'd0, any_valid}, 32'd0);
    check("no_resume_active", act_cnt, snap);

    ident_m = 16'd0;
    send_frame(17, 8'h88, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
